// File: rtl/mem_arbiter_if.sv
// Bundle of the requestor-side and RAM-side signals of the memory arbiter.
// The master modport is the arbiter's view; slave is the view of its surroundings.
interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        memerr;

    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
    );

    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction and data requestors onto a single variable-latency RAM,
// one access at a time, with a watchdog that aborts accesses the RAM never finishes.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 64,
    parameter logic [31:0] BADVAL  = 32'hBAD1BAD1
) (
    input logic           CLK,
    input logic           RST,
    mem_arbiter_if.master bus
);
    typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;
    typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} state_t;
    typedef enum logic {GNT_I, GNT_D} gnt_t;

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    state_t      state_q;
    gnt_t        gnt_q;
    gnt_t        lastgnt_q;
    logic [CW-1:0] cnt_q;
    logic        ren_q;
    logic        wen_q;
    logic        memerr_q;
    logic [31:0] addr_q;
    logic [31:0] store_q;

    ramstate_t   rs;
    logic        dreq;
    logic        pick_i;
    logic        ok;
    logic        done;
    logic [31:0] load;

    always_comb begin
        rs     = ramstate_t'(bus.ramstate);
        dreq   = bus.dREN | bus.dWEN;
        // Data normally wins; instruction wins only when data had the last grant.
        pick_i = bus.iREN & (~dreq | (lastgnt_q == GNT_D));
        ok     = (state_q == ISSUE) && (rs == ACCESS);
        done   = (state_q == ISSUE) &&
                 ((rs == ACCESS) || (rs == ERROR) || (cnt_q == CW'(TIMEOUT - 1)));
        load   = ok ? bus.ramload : BADVAL;
    end

    assign bus.iwait    = bus.iREN & ~(done & (gnt_q == GNT_I));
    assign bus.dwait    = dreq & ~(done & (gnt_q == GNT_D));
    assign bus.iload    = (done && gnt_q == GNT_I) ? load : BADVAL;
    assign bus.dload    = (done && gnt_q == GNT_D) ? load : BADVAL;
    assign bus.ramREN   = ren_q;
    assign bus.ramWEN   = wen_q;
    assign bus.ramaddr  = addr_q;
    assign bus.ramstore = store_q;
    assign bus.memerr   = memerr_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            gnt_q     <= GNT_I;
            lastgnt_q <= GNT_I;
            cnt_q     <= '0;
            ren_q     <= 1'b0;
            wen_q     <= 1'b0;
            memerr_q  <= 1'b0;
            addr_q    <= '0;
            store_q   <= '0;
        end else begin
            memerr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_i || dreq) begin
                        gnt_q   <= pick_i ? GNT_I : GNT_D;
                        addr_q  <= pick_i ? bus.iaddr : bus.daddr;
                        store_q <= pick_i ? store_q : bus.dstore;
                        // A data write takes precedence over a simultaneous data read.
                        wen_q   <= ~pick_i & bus.dWEN;
                        ren_q   <= pick_i | ~bus.dWEN;
                        cnt_q   <= '0;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (done) begin
                        if (ok) lastgnt_q <= gnt_q;
                        else    memerr_q  <= 1'b1;
                        // Enables drop for the RELEASE cycle so the RAM restarts its count.
                        ren_q   <= 1'b0;
                        wen_q   <= 1'b0;
                        state_q <= RELEASE;
                    end
                end
                RELEASE: begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small latency-programmable RAM model.
module tb_mem_arbiter;
    localparam logic [31:0] BAD = 32'hBAD1BAD1;
    localparam int LAT = 5;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   nvec = 0;
    int   nerr = 0;
    int   ram_mode = 0;  // 0 normal, 1 stuck busy, 2 error on 3rd ISSUE cycle
    int   rcnt = 0;
    logic [31:0] mem [256];

    mem_arbiter_if bus ();

    mem_arbiter #(.TIMEOUT(64), .BADVAL(32'hBAD1BAD1)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus.master)
    );

    always #5 CLK = ~CLK;

    // RAM model: ACCESS arrives once the enable has been held LAT+1 prior cycles.
    always @(posedge CLK) begin
        if (RST) begin
            rcnt    <= 0;
            mem[16] <= 32'h12345678;
            mem[64] <= 32'h11111111;
        end else begin
            if (bus.ramREN || bus.ramWEN) rcnt <= rcnt + 1;
            else                          rcnt <= 0;
            if (bus.ramWEN && bus.ramstate == 2'd2) mem[bus.ramaddr[9:2]] <= bus.ramstore;
        end
    end

    always_comb begin
        bus.ramload = mem[bus.ramaddr[9:2]];
        if (!(bus.ramREN || bus.ramWEN))     bus.ramstate = 2'd0;
        else if (ram_mode == 1)              bus.ramstate = 2'd1;
        else if (ram_mode == 2 && rcnt == 2) bus.ramstate = 2'd3;
        else if (rcnt == LAT + 1)            bus.ramstate = 2'd2;
        else                                 bus.ramstate = 2'd1;
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        bus.iREN = 0; bus.iaddr = '0; bus.dREN = 0; bus.dWEN = 0;
        bus.daddr = '0; bus.dstore = '0;
        cyc(); cyc();
        nvec++; if (bus.ramREN !== 1'b0) begin nerr++; $display("FAIL reset_ramREN got %b want 0", bus.ramREN); end
        nvec++; if (bus.ramWEN !== 1'b0) begin nerr++; $display("FAIL reset_ramWEN got %b want 0", bus.ramWEN); end
        nvec++; if (bus.ramaddr !== 32'h0) begin nerr++; $display("FAIL reset_ramaddr got %h want 0", bus.ramaddr); end
        nvec++; if (bus.ramstore !== 32'h0) begin nerr++; $display("FAIL reset_ramstore got %h want 0", bus.ramstore); end
        nvec++; if (bus.memerr !== 1'b0) begin nerr++; $display("FAIL reset_memerr got %b want 0", bus.memerr); end
        nvec++; if (bus.dload !== BAD) begin nerr++; $display("FAIL reset_dload got %h want %h", bus.dload, BAD); end
        RST = 1'b0;
        cyc();
    endtask

    task automatic test_single_read();
        bus.dREN = 1; bus.daddr = 32'h40;  // cycle 0, IDLE
        cyc();
        nvec++; if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h40) begin nerr++;
            $display("FAIL rd_issue got ren=%b addr=%h want ren=1 addr=00000040", bus.ramREN, bus.ramaddr); end
        for (int k = 2; k <= 6; k++) cyc();
        nvec++; if (bus.dwait !== 1'b1) begin nerr++; $display("FAIL rd_wait_c6 got %b want 1", bus.dwait); end
        cyc();
        nvec++; if (bus.dwait !== 1'b0 || bus.dload !== 32'h12345678) begin nerr++;
            $display("FAIL rd_done_c7 got wait=%b load=%h want wait=0 load=12345678", bus.dwait, bus.dload); end
        bus.dREN = 0;
        cyc();
        nvec++; if (bus.ramREN !== 1'b0 || bus.ramaddr !== 32'h40) begin nerr++;
            $display("FAIL rd_release_c8 got ren=%b addr=%h want ren=0 addr=00000040", bus.ramREN, bus.ramaddr); end
        cyc();
    endtask

    task automatic test_write_read();
        int wen_n = 0, ren_n = 0, merr_n = 0;
        logic fin = 0;
        bus.dWEN = 1; bus.dREN = 1; bus.daddr = 32'h80; bus.dstore = 32'hCAFEF00D;
        for (int n = 0; n < 100; n++) begin
            cyc();
            if (bus.ramWEN) wen_n++;
            if (bus.ramREN) ren_n++;
            if (bus.memerr) merr_n++;
            if (!bus.dwait) begin fin = 1; break; end
        end
        nvec++; if (fin !== 1'b1) begin nerr++; $display("FAIL wr_complete got %b want 1", fin); end
        nvec++; if (wen_n != 7 || ren_n != 0) begin nerr++;
            $display("FAIL wr_enables got wen=%0d ren=%0d want wen=7 ren=0", wen_n, ren_n); end
        bus.dWEN = 0; bus.dREN = 1;
        fin = 0;
        for (int n = 0; n < 100; n++) begin
            cyc();
            if (bus.ramWEN) wen_n++;
            if (bus.memerr) merr_n++;
            if (!bus.dwait) begin fin = 1; break; end
        end
        nvec++; if (fin !== 1'b1 || bus.dload !== 32'hCAFEF00D) begin nerr++;
            $display("FAIL wr_readback got done=%b load=%h want done=1 load=cafef00d", fin, bus.dload); end
        bus.dREN = 0;
        cyc();
        if (bus.memerr) merr_n++;
        nvec++; if (wen_n != 7 || merr_n != 0) begin nerr++;
            $display("FAIL wr_totals got wen=%0d memerr=%0d want 7 0", wen_n, merr_n); end
        cyc();
    endtask

    task automatic test_contention();
        int   seen = 0;
        logic rel_chk = 0;
        logic [1:0] got, want;
        logic [31:0] gl, wl;
        RST = 1;
        bus.iREN = 1; bus.iaddr = 32'h100; bus.dREN = 1; bus.dWEN = 0; bus.daddr = 32'h40;
        cyc();
        RST = 0;
        for (int n = 0; n < 200 && seen < 4; n++) begin
            cyc();
            if (rel_chk) begin
                rel_chk = 0;
                nvec++; if (bus.ramREN !== 1'b0) begin nerr++; $display("FAIL cont_release%0d got ren=%b want 0", seen, bus.ramREN); end
            end
            if (!bus.dwait || !bus.iwait) begin
                got  = {~bus.dwait, ~bus.iwait};
                want = (seen % 2 == 0) ? 2'b10 : 2'b01;
                gl   = (seen % 2 == 0) ? bus.dload : bus.iload;
                wl   = (seen % 2 == 0) ? 32'h12345678 : 32'h11111111;
                nvec++; if (got !== want || gl !== wl) begin nerr++;
                    $display("FAIL cont_grant%0d got d/i=%b load=%h want %b %h", seen, got, gl, want, wl); end
                seen++;
                rel_chk = 1;
            end
        end
        nvec++; if (seen != 4) begin nerr++; $display("FAIL cont_count got %0d want 4", seen); end
        bus.iREN = 0; bus.dREN = 0;
        cyc(); cyc(); cyc();
    endtask

    task automatic test_timeout();
        ram_mode = 1;
        bus.dREN = 1; bus.daddr = 32'h40;
        for (int k = 1; k <= 63; k++) cyc();
        nvec++; if (bus.dwait !== 1'b1) begin nerr++; $display("FAIL to_wait_c63 got %b want 1", bus.dwait); end
        cyc();
        nvec++; if (bus.dwait !== 1'b0 || bus.dload !== BAD || bus.memerr !== 1'b0) begin nerr++;
            $display("FAIL to_done_c64 got wait=%b load=%h err=%b want 0 %h 0", bus.dwait, bus.dload, bus.memerr, BAD); end
        bus.dREN = 0;
        cyc();
        nvec++; if (bus.memerr !== 1'b1 || bus.ramREN !== 1'b0) begin nerr++;
            $display("FAIL to_memerr_c65 got err=%b ren=%b want 1 0", bus.memerr, bus.ramREN); end
        cyc();
        nvec++; if (bus.memerr !== 1'b0) begin nerr++; $display("FAIL to_memerr_c66 got %b want 0", bus.memerr); end
        ram_mode = 0;
        cyc();
    endtask

    task automatic test_fault();
        int   lat = 0;
        logic fin = 0;
        ram_mode = 2;
        bus.dREN = 1; bus.daddr = 32'h40;
        cyc(); cyc();
        nvec++; if (bus.dwait !== 1'b1) begin nerr++; $display("FAIL err_wait_c2 got %b want 1", bus.dwait); end
        cyc();
        nvec++; if (bus.dwait !== 1'b0 || bus.dload !== BAD) begin nerr++;
            $display("FAIL err_done_c3 got wait=%b load=%h want 0 %h", bus.dwait, bus.dload, BAD); end
        bus.dREN = 0;
        cyc();
        nvec++; if (bus.memerr !== 1'b1) begin nerr++; $display("FAIL err_memerr got %b want 1", bus.memerr); end
        ram_mode = 0;
        cyc();
        bus.iREN = 1; bus.iaddr = 32'h100;
        for (int n = 0; n < 100; n++) begin
            cyc(); lat++;
            if (!bus.iwait) begin fin = 1; break; end
        end
        nvec++; if (fin !== 1'b1 || lat != 7 || bus.iload !== 32'h11111111 || bus.memerr !== 1'b0 || bus.ramWEN !== 1'b0) begin nerr++;
            $display("FAIL err_next_read got done=%b lat=%0d load=%h err=%b wen=%b want 1 7 11111111 0 0",
                     fin, lat, bus.iload, bus.memerr, bus.ramWEN); end
        bus.iREN = 0;
        cyc(); cyc();
    endtask

    task automatic test_reset_mid();
        int   lat = 0;
        logic fin = 0;
        bus.dREN = 1; bus.daddr = 32'h40;
        cyc(); cyc(); cyc();
        RST = 1;
        cyc();
        nvec++; if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0 || bus.memerr !== 1'b0 || bus.dwait !== 1'b1) begin nerr++;
            $display("FAIL rst_mid got ren=%b wen=%b err=%b wait=%b want 0 0 0 1", bus.ramREN, bus.ramWEN, bus.memerr, bus.dwait); end
        RST = 0;
        for (int n = 0; n < 100; n++) begin
            cyc(); lat++;
            if (!bus.dwait) begin fin = 1; break; end
        end
        nvec++; if (fin !== 1'b1 || lat != 7 || bus.dload !== 32'h12345678) begin nerr++;
            $display("FAIL rst_retry got done=%b lat=%0d load=%h want 1 7 12345678", fin, lat, bus.dload); end
        bus.dREN = 0;
        cyc(); cyc();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_read();
        test_contention();
        test_timeout();
        test_fault();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish by 200000");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Initiator end of the CPU–RAM interface. Arbitrates between an instruction-fetch requestor and a data requestor.
- Drives ramREN/ramWEN/ramaddr/ramstore toward the variable-latency RAM and waits on ramstate.
- Holds each access stable until the RAM reports ACCESS, then returns data and wait=0 to the winning requestor.
- Sits between the caches/datapath and the RAM; adds a watchdog timeout and fault reporting.

Parameters:
- TIMEOUT, 64: max cycles in ISSUE before the access is aborted.
- BADVAL, 32'hBAD1BAD1: load value returned on an aborted access.

Ports:
- CLK  in  1  clock
- RST  in  1  reset; synchronous, active-high
- iREN  in  1  instruction read request
- iaddr  in  32  instruction address
- iwait  out  1  instruction stall
- iload  out  32  instruction read data
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  32  data address
- dstore  in  32  data write value
- dwait  out  1  data stall
- dload  out  32  data read data
- ramREN  out  1  RAM read enable (registered)
- ramWEN  out  1  RAM write enable (registered)
- ramaddr  out  32  RAM address (registered)
- ramstore  out  32  RAM write data (registered)
- ramload  in  32  RAM read data
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
- memerr  out  1  one-cycle pulse on aborted access (registered)

Behaviour:
- Reset (RST high at posedge):
  - state=IDLE; ramREN=ramWEN=0; ramaddr=ramstore=0; memerr=0; lastgnt=I; timeout counter=0.
  - RST mid-transaction drops the access immediately. The requestor keeps wait=1 and retries after reset.
- States:
  - IDLE:
    - Pick a grant if any request is pending.
    - Data has priority, unless lastgnt==D and iREN is also pending; then instruction wins (alternation under contention).
    - On grant, register ramaddr/ramstore/ramREN/ramWEN from the winner and go to ISSUE.
    - Data request with dWEN=1 issues a write (ramWEN=1, ramREN=0) even if dREN=1. Otherwise it issues a read.
    - Instruction requests are always reads.
  - ISSUE:
    - Hold RAM outputs constant. Counter increments each cycle.
    - ramstate==ACCESS: winner's wait=0 this cycle. Winner's load=ramload (reads only). lastgnt<=winner. Go to RELEASE.
    - ramstate==ERROR, or counter==TIMEOUT-1 without ACCESS: winner's wait=0, load=BADVAL, memerr=1 next cycle, go to RELEASE.
  - RELEASE:
    - ramREN=ramWEN=0 for exactly one cycle so the RAM restarts its latency count. ramaddr unchanged.
    - Go to IDLE. Counter clears.
- Wait rules (combinational):
  - iwait = iREN and not (state==ISSUE, grant==I, completing this cycle).
  - dwait = (dREN or dWEN) and not (state==ISSUE, grant==D, completing this cycle).
  - Requestors hold address/data stable while wait=1.
  - Deasserting the request mid-ISSUE does not abort; the access completes and the result is discarded.
- iload/dload = ramload in the completing cycle, else BADVAL.
- Minimum request-to-completion cost is 2 cycles plus RAM latency. Each transaction also costs 1 RELEASE cycle.
- No pipelining; one outstanding RAM access.

Test Plan:
- Single read, RAM LAT=5, mem[0x40]=0x12345678: dREN=1, daddr=0x40 seen in IDLE at cycle 0.
  - ramREN=1, ramaddr=0x40 from cycle 1.
  - dwait=0, dload=0x12345678 in cycle 7.
  - ramREN=0 in cycle 8.
- Write then read: dWEN=1, daddr=0x80, dstore=0xCAFEF00D until dwait=0, then dREN=1, same addr.
  - ramWEN seen high exactly during one ISSUE phase.
  - Read returns 0xCAFEF00D; no memerr.
- Contention: iREN and dREN held continuously from reset release.
  - Grants alternate D, I, D, I; each completion separated by one RELEASE cycle with ramREN=0.
- Timeout: RAM model forced permanently BUSY, TIMEOUT=64, dREN=1.
  - dwait=0 with dload=0xBAD1BAD1 on the 64th ISSUE cycle; memerr pulses one cycle later.
- Fault: RAM model returns ERROR on cycle 3 of ISSUE.
  - Immediate completion with BADVAL and a memerr pulse.
  - Next request proceeds normally.
- Reset mid-access: RST=1 on cycle 3 of ISSUE.
  - Next cycle ramREN=ramWEN=0, memerr=0, state IDLE.
  - After RST drops, the held request re-issues and completes with correct data.
